// File: rtl/iru_rot_ctrl.sv
// Rotation-unit sequencer: raster-scans a 20x20 window, reads each mapped source pixel
// (or substitutes FILL) and streams the result to the destination buffer under backpressure.
module iru_rot_ctrl #(
    parameter int               PIX_W = 8,
    parameter logic [PIX_W-1:0] FILL  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [35:0]      rnn_in,
    output logic             busy,
    output logic             done,
    output logic [35:0]      rnn_out,
    output logic [4:0]       row_d,
    output logic [4:0]       col_d,
    input  logic             comp_valid,
    input  logic [4:0]       comp_row_q,
    input  logic [4:0]       comp_col_q,
    output logic             src_rd_en,
    output logic [8:0]       src_rd_addr,
    input  logic [PIX_W-1:0] src_rd_data,
    output logic             dst_wr_en,
    output logic [8:0]       dst_wr_addr,
    output logic [PIX_W-1:0] dst_wr_data,
    input  logic             dst_ready
);
    // Handshake: a destination write completes on any rising edge where dst_wr_en and
    // dst_ready are both high; dst_wr_en and the dst_* fields are held until that edge.

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t           state;
    logic             s1_vld;
    logic             s1_ok;
    logic             s1_pend;
    logic [8:0]       s1_addr;
    logic [PIX_W-1:0] s1_data;

    logic adv;
    logic issue;
    logic last_pt;
    logic final_wr;

    assign adv      = ~dst_wr_en | dst_ready;
    assign issue    = (state == SCAN) & adv;
    assign last_pt  = (row_d == 5'd19) & (col_d == 5'd19);
    assign final_wr = (state == DRAIN) & dst_wr_en & dst_ready & ~s1_vld;

    assign src_rd_en   = issue & comp_valid;
    assign src_rd_addr = src_rd_en ? (9'(comp_row_q) * 9'd20 + 9'(comp_col_q)) : 9'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rnn_out     <= '0;
            row_d       <= '0;
            col_d       <= '0;
            s1_vld      <= 1'b0;
            s1_ok       <= 1'b0;
            s1_pend     <= 1'b0;
            s1_addr     <= '0;
            s1_data     <= '0;
            dst_wr_en   <= 1'b0;
            dst_wr_addr <= '0;
            dst_wr_data <= '0;
        end else begin
            done <= 1'b0;

            // Read data is only valid for one cycle, so it is captured even during a stall.
            if (s1_pend) begin
                s1_data <= src_rd_data;
                s1_pend <= 1'b0;
            end

            if (adv) begin
                dst_wr_en <= s1_vld;
                if (s1_vld) begin
                    dst_wr_addr <= s1_addr;
                    dst_wr_data <= s1_ok ? (s1_pend ? src_rd_data : s1_data) : FILL;
                end
                s1_vld  <= issue;
                s1_pend <= src_rd_en;
                s1_ok   <= issue & comp_valid;
                if (issue) begin
                    s1_addr <= 9'(row_d) * 9'd20 + 9'(col_d);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SCAN;
                        busy    <= 1'b1;
                        rnn_out <= rnn_in;
                        row_d   <= '0;
                        col_d   <= '0;
                    end
                end
                SCAN: begin
                    if (adv) begin
                        if (col_d == 5'd19) begin
                            col_d <= '0;
                            row_d <= (row_d == 5'd19) ? 5'd0 : row_d + 5'd1;
                        end else begin
                            col_d <= col_d + 5'd1;
                        end
                        if (last_pt) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (final_wr) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iru_rot_ctrl.sv
// Randomised scoreboard bench for iru_rot_ctrl: a comp-unit/source-buffer model drives the DUT,
// the expected 400-write image is queued per run and a negedge monitor checks every write.
module tb_iru_rot_ctrl;
    localparam logic [7:0] FILL_V = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [35:0] rnn_in = '0;
    logic        busy, done;
    logic [35:0] rnn_out;
    logic [4:0]  row_d, col_d;
    logic        comp_valid;
    logic [4:0]  comp_row_q, comp_col_q;
    logic        src_rd_en;
    logic [8:0]  src_rd_addr;
    logic [7:0]  src_rd_data = '0;
    logic        dst_wr_en;
    logic [8:0]  dst_wr_addr;
    logic [7:0]  dst_wr_data;
    logic        dst_ready = 1'b1;

    iru_rot_ctrl #(.PIX_W(8), .FILL(FILL_V)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rnn_in(rnn_in),
        .busy(busy), .done(done), .rnn_out(rnn_out),
        .row_d(row_d), .col_d(col_d),
        .comp_valid(comp_valid), .comp_row_q(comp_row_q), .comp_col_q(comp_col_q),
        .src_rd_en(src_rd_en), .src_rd_addr(src_rd_addr), .src_rd_data(src_rd_data),
        .dst_wr_en(dst_wr_en), .dst_wr_addr(dst_wr_addr), .dst_wr_data(dst_wr_data),
        .dst_ready(dst_ready)
    );

    // clock / reset
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [16:0] exp_q[$];   // {addr, data}
    logic [7:0]  mem [0:511];
    int map_mode = 0;        // 0 identity, 1 all invalid, 2 quarter turn with offset
    int bp_mode  = 0;        // 0 always ready, 1 random 50%, 2 five-cycle stall after first read
    int t0 = 0;

    int wr_cnt, rd_cnt, first_rd, first_wr, done_cyc;
    bit done_seen, busy_at_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // comp unit model: {valid, src_row, src_col}
    function automatic logic [10:0] map_pt(input int mode, input logic [4:0] r, input logic [4:0] c);
        case (mode)
            0: return {1'b1, r, c};
            1: return {1'b0, 5'((r * 7 + c) % 32), c ^ r};
            default: return {(r + 3) < 20, 5'(19 - c), 5'(r + 3)};
        endcase
    endfunction

    always_comb {comp_valid, comp_row_q, comp_col_q} = map_pt(map_mode, row_d, col_d);

    // source buffer: data valid exactly one cycle after the strobe, garbage otherwise
    always @(posedge clk) src_rd_data <= src_rd_en ? mem[src_rd_addr] : 8'($urandom);

    // destination backpressure driver
    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0: dst_ready = 1'b1;
            1: dst_ready = 1'($urandom_range(0, 1));
            default: dst_ready = !(cyc >= t0 + 2 && cyc <= t0 + 6);
        endcase
    end

    // monitor / scoreboard
    initial begin
        bit prev_stall = 0;
        logic [27:0] prev_out = '0;
        logic [10:0] m;
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
            end else begin
                if (prev_stall)
                    check("stall_hold", {dst_wr_en, dst_wr_addr, dst_wr_data, row_d, col_d}, prev_out);
                if (dst_wr_en && !dst_ready)
                    check("stall_no_read", src_rd_en, 1'b0);
                if (src_rd_en) begin
                    rd_cnt++;
                    if (first_rd < 0) first_rd = cyc;
                    m = map_pt(map_mode, row_d, col_d);
                    check("rd_addr", src_rd_addr, 9'(m[9:5]) * 9'd20 + 9'(m[4:0]));
                end
                if (dst_wr_en && first_wr < 0) first_wr = cyc;
                if (dst_wr_en && dst_ready) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: addr %0d data %0h", dst_wr_addr, dst_wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", {dst_wr_addr, dst_wr_data}, e);
                    end
                end
                if (done) begin
                    done_seen = 1;
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
                prev_stall = dst_wr_en && !dst_ready;
                prev_out = {dst_wr_en, dst_wr_addr, dst_wr_data, row_d, col_d};
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        check(name, {busy, done, src_rd_en, dst_wr_en, rnn_out, row_d, col_d,
                     src_rd_addr, dst_wr_addr, dst_wr_data}, '0);
    endtask

    task automatic run_scan(input int mmode, input int bmode, input bit ident_mem,
                            input bit timing, input bit poke, input int abort_at);
        logic [35:0] rnn;
        logic [10:0] m;
        logic [7:0]  d;
        bit ended = 0;
        map_mode = mmode;
        bp_mode  = bmode;
        for (int a = 0; a < 512; a++) mem[a] = ident_mem ? 8'(a) : 8'($urandom);
        for (int p = 0; p < 400; p++) begin
            m = map_pt(mmode, 5'(p / 20), 5'(p % 20));
            d = m[10] ? mem[m[9:5] * 20 + m[4:0]] : FILL_V;
            exp_q.push_back({9'(p), d});
        end
        wr_cnt = 0; rd_cnt = 0; first_rd = -1; first_wr = -1; done_cyc = -1;
        done_seen = 0; busy_at_done = 1;
        rnn = {4'($urandom), 32'($urandom)};
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b1;
        rnn_in = rnn;
        @(posedge clk);
        #1;
        start = 1'b0;
        rnn_in = ~rnn;
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk);
            if (poke && i == 100) begin #1; start = 1'b1; rnn_in = rnn ^ 36'h5_A5A5_A5A5; end
            if (poke && i == 101) begin #1; start = 1'b0; end
            if (done_seen || (abort_at > 0 && wr_cnt >= abort_at)) begin
                ended = 1;
                break;
            end
        end
        if (!ended) begin
            tests++;
            fails++;
            $display("FAIL timeout: run with map %0d bp %0d wrote %0d", mmode, bmode, wr_cnt);
        end
        if (abort_at > 0) begin
            @(negedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check_reset_outputs("async_reset_outputs");
            exp_q.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            @(negedge clk);
            check("rnn_out_stable", rnn_out, rnn);
            check("writes_400", wr_cnt, 400);
            check("queue_empty", exp_q.size(), 0);
            check("busy_low_at_done", busy_at_done, 1'b0);
            if (mmode == 0) check("reads_400", rd_cnt, 400);
            if (mmode == 1) check("reads_0", rd_cnt, 0);
            if (timing) begin
                check("first_rd_lat", first_rd, t0 + 1);
                check("first_wr_lat", first_wr, t0 + 3);
                check("done_lat", done_cyc, t0 + 403);
            end
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_outputs");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_scan(0, 0, 1, 1, 0, 0);   // identity, no stalls, latency checks
        run_scan(1, 0, 0, 0, 0, 0);   // all invalid -> FILL, no reads
        run_scan(2, 1, 0, 0, 0, 0);   // rotated mapping, random backpressure
        run_scan(0, 1, 0, 0, 0, 0);   // identity, random backpressure
        run_scan(2, 2, 0, 0, 0, 0);   // stall right after first read
        run_scan(2, 0, 0, 0, 1, 0);   // start pulsed while busy
        run_scan(0, 1, 0, 0, 0, 150); // reset at write 150
        run_scan(2, 1, 0, 0, 0, 0);   // full restart after reset
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iru_rot_ctrl.md
# iru_rot_ctrl

Sequencer for the image rotation unit's coordinate computation unit. It accepts a start command with a 36-bit RNN angle code and scans all 400 destination pixels of a 20×20 window in raster order, driving the comp unit with each (row, col). For each pixel it reads the mapped source pixel from the source window buffer, or substitutes a fill value when the comp unit flags the mapping invalid. It streams the rotated window to the destination buffer under backpressure.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits.
- `FILL`, 0: value written for pixels whose rotated source lies outside the window (`PIX_W` bits).

Ports:
- `clk` in 1: clock, all state on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: start request, accepted only while `busy`=0.
- `rnn_in` in 36: angle code, sampled when `start` is accepted.
- `busy` out 1: high from the accepted start until `done`.
- `done` out 1: one-cycle pulse after the last write handshake.
- `rnn_out` out 36: latched angle code driven to the comp unit.
- `row_d`, `col_d` out 5 each: scan coordinate driven to the comp unit.
- `comp_valid` in 1: comp unit in-range flag, combinational from `row_d`/`col_d`.
- `comp_row_q`, `comp_col_q` in 5 each: comp unit source coordinate.
- `src_rd_en` out 1: source buffer read strobe.
- `src_rd_addr` out 9: source address, `comp_row_q*20+comp_col_q`.
- `src_rd_data` in `PIX_W`: read data, valid exactly 1 cycle after `src_rd_en`.
- `dst_wr_en` out 1: destination write valid. Registered and held until accepted.
- `dst_wr_addr` out 9: destination address, `row*20+col` of the scan point.
- `dst_wr_data` out `PIX_W`: destination pixel.
- `dst_ready` in 1: destination accepts the write when `dst_wr_en` and `dst_ready` are both high.

## Operation
- **FSM states**:
  - IDLE → SCAN on `start` when `busy`=0. Latch `rnn_in` into `rnn_out` and clear the row/col counters.
  - SCAN → DRAIN when the issue at (19,19) advances.
  - DRAIN → IDLE when the final write handshakes. Pulse `done` in the following cycle.
- **Pipeline**:
  - S0 is the scan counter feeding the comp unit.
  - S1 holds the dst address, the valid flag, and the captured read data.
  - S2 is the output register.
- **Advance condition**: `adv = ~dst_wr_en | dst_ready`. Every stage moves only when `adv`=1.
- **Issue in SCAN with adv=1**:
  - Assert `src_rd_en` only if `comp_valid`=1.
  - Load S1 with {`row*20+col`, `comp_valid`}.
  - Increment `col`. Wrap 19→0 and increment `row`.
- **S1 data capture**: S1 captures `src_rd_data` in the cycle after its read, even if stalled. It never re-reads.
- **S1→S2 move**: `dst_wr_data` = captured data if valid, else `FILL`.
- **Address arithmetic**: 9-bit unsigned, range 0..399. `comp_row_q`/`comp_col_q` are used only when `comp_valid`=1. An invalid mapping never produces a read.
- **`start` while `busy`**: ignored. `rnn_out` is stable for the whole scan.
- **Reset mid-scan**: all state clears immediately and no further writes are issued. The destination may hold a partial image, and the caller restarts.

## Timing
- **Reset values**: `busy`, `done`, `src_rd_en`, `dst_wr_en` = 0. `rnn_out`, `row_d`, `col_d`, `src_rd_addr`, `dst_wr_addr`, `dst_wr_data` = 0.
- **Latency**: start accepted at cycle T; first `src_rd_en` at T+1; first `dst_wr_en` at T+3.
- **Throughput**: with `dst_ready`=1, one write per cycle. The last write is at T+402 and `done` is at T+403. `busy` falls together with `done`.
- **Stall**: while `dst_wr_en`=1 and `dst_ready`=0, all of the following hold:
  - no `src_rd_en`;
  - the counters are frozen;
  - the `dst_*` outputs are held stable.
- **Next start**: a new `start` is accepted in the cycle after `done`.

## Test plan
- **Identity angle** (comp unit maps (r,c)→(r,c), valid): `dst_ready`=1 and source pixel = address.
  - Required: 400 writes with `dst_wr_data`==`dst_wr_addr`[7:0] in order 0..399.
  - Required: `done` at T+403.
- **All-invalid mapping** (`comp_valid`=0): required zero `src_rd_en`, 400 writes of `FILL`.
- **Backpressure**: toggle `dst_ready` randomly at 50%.
  - Required: outputs stable during stalls.
  - Required: no write lost or duplicated, and the sequence matches the no-stall run.
- **Stall with captured data**: hold `dst_ready`=0 for 5 cycles right after the first read.
  - Required: the S1 pixel equals the value presented 1 cycle after its read.
  - Required: `src_rd_data` changing afterwards has no effect.
- **Busy start**: pulse `start` with a different `rnn_in` mid-scan.
  - Required: ignored, `rnn_out` unchanged, 400 writes only.
- **Async reset**: drop `rst_n` at write 150.
  - Required: all outputs at reset values immediately.
  - Required: a new start gives a full 400-write run beginning at address 0.
